// File: rtl/uart_rx_byte_fifo.sv
// UART receiver with a 2-flop synchroniser and oversampled start/data/stop validation.
// Received bytes go into a first-word-fall-through FIFO that the consumer drains with valid/ready.
module uart_rx_byte_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic                        start_rx,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun
);
  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [1:0]       rxSync_q;
  logic             rxs;
  state_e           state_q;
  logic [DIV_W-1:0] divCnt_q;
  logic [OVS_W-1:0] tickCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic             frameErr_q;
  logic             overrun_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick, stopSample, full, push, pop;

  // Synchroniser flops idle high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxSync_q <= 2'b11;
    else        rxSync_q <= {rxSync_q[0], rx};
  end

  assign rxs        = rxSync_q[1];
  assign tick       = (state_q != IDLE) && (divCnt_q == DIV_W'(DIV - 1));
  assign stopSample = (state_q == STOP) && tick && (tickCnt_q == OVS_W'(OVERSAMPLE - 1));
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = data_valid && data_ready;
  assign push       = stopSample && rxs && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      divCnt_q   <= '0;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= stopSample && !rxs;
      overrun_q  <= stopSample && rxs && full && !pop;
      if (state_q == IDLE || tick) divCnt_q <= '0;
      else                         divCnt_q <= divCnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start_rx && !rxs) begin
            state_q   <= START;
            tickCnt_q <= '0;
          end
        end
        // A start bit that is high again at its midpoint was only a glitch.
        START: begin
          if (tick) begin
            if (tickCnt_q == OVS_W'(OVERSAMPLE / 2 - 1)) begin
              tickCnt_q <= '0;
              bitCnt_q  <= '0;
              state_q   <= rxs ? IDLE : DATA;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tickCnt_q == OVS_W'(OVERSAMPLE - 1)) begin
              tickCnt_q <= '0;
              shift_q   <= {rxs, shift_q[7:1]};
              bitCnt_q  <= bitCnt_q + 1'b1;
              if (bitCnt_q == 3'd7) state_q <= STOP;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tickCnt_q == OVS_W'(OVERSAMPLE - 1)) begin
              tickCnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) mem_q[wrPtr_q] <= shift_q;
    end
  end

  assign data_out   = mem_q[rdPtr_q];
  assign data_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Bench for uart_rx_byte_fifo: frame table plus glitch and mid-frame reset sequences,
// with a byte scoreboard drained by a monitor on every accepted pop.
module tb_uart_rx_byte_fifo;
  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       start_rx = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  int vecCnt = 0;
  int missCnt = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  int riseCycle = -1;
  int feSeen = 0;
  int ovSeen = 0;
  logic prevValid = 1'b0;
  logic prevFe = 1'b0;
  logic prevOv = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       startRx;
    int         dropBit;
    logic       ready;
    logic       expAccept;
    int         expFe;
    int         expOv;
    int         expCount;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  uart_rx_byte_fifo #(
    .CLOCK_FREQ(1600000),
    .BAUD_RATE (10000),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .start_rx  (start_rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCnt++;
    if (actual !== expected) begin
      missCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkLatency(input string name);
    int diff;
    diff = riseCycle - startCycle;
    vecCnt++;
    if (riseCycle < 0 || diff < 1522 || diff > 1524) begin
      missCnt++;
      $display("[TB] FAIL %s: data_valid rose %0d clk after start edge, expected 1522..1524", name, diff);
    end
  endtask

  // Drives one 8N1 frame; start_rx can be dropped at the start of a chosen data bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int dropBit);
    @(negedge clk);
    rx = 1'b0;
    startCycle = cycleCnt;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == dropBit) start_rx = 1'b0;
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stopBit;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (data_valid && !prevValid) riseCycle = cycleCnt;
    if (data_valid && data_ready) begin
      if (sb.size() == 0) begin
        vecCnt++;
        missCnt++;
        $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no byte", data_out);
      end else begin
        checkOutput("pop_data", {24'd0, data_out}, {24'd0, sb.pop_front()});
      end
    end
    if (frame_err) begin
      feSeen++;
      checkOutput("frame_err_width", {31'd0, prevFe}, 32'd0);
      checkOutput("fe_ov_exclusive", {31'd0, overrun}, 32'd0);
    end
    if (overrun) begin
      ovSeen++;
      checkOutput("overrun_width", {31'd0, prevOv}, 32'd0);
    end
    prevValid = data_valid;
    prevFe    = frame_err;
    prevOv    = overrun;
  end

  initial begin
    int fe0, ov0, prevExpCount;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, -1, 1'b1, 1'b1, 0, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1, 0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, -1, 1'b1, 1'b1, 0, 0, 0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, -1, 1'b0, 1'b1, 0, 0, 1};
    vecs[4] = '{8'h02, 1'b1, 1'b1, -1, 1'b0, 1'b1, 0, 0, 2};
    vecs[5] = '{8'h03, 1'b1, 1'b1, -1, 1'b0, 1'b1, 0, 0, 3};
    vecs[6] = '{8'h04, 1'b1, 1'b1, -1, 1'b0, 1'b1, 0, 0, 4};
    vecs[7] = '{8'h05, 1'b1, 1'b1, -1, 1'b0, 1'b0, 0, 1, 4};
    vecs[8] = '{8'h55, 1'b1, 1'b0, -1, 1'b1, 1'b0, 0, 0, 0};
    vecs[9] = '{8'h66, 1'b1, 1'b1,  3, 1'b1, 1'b1, 0, 0, 0};

    repeat (3) @(negedge clk);
    checkOutput("reset_data_out",   {24'd0, data_out},   32'd0);
    checkOutput("reset_data_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset_frame_err",  {31'd0, frame_err},  32'd0);
    checkOutput("reset_overrun",    {31'd0, overrun},    32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    prevExpCount = 0;
    for (int v = 0; v < 10; v++) begin
      start_rx   = vecs[v].startRx;
      data_ready = vecs[v].ready;
      fe0 = feSeen;
      ov0 = ovSeen;
      riseCycle = -1;
      if (vecs[v].expAccept) sb.push_back(vecs[v].data);
      applyStimulus(vecs[v].data, vecs[v].stopBit, vecs[v].dropBit);
      checkOutput("row_frame_err", feSeen - fe0, vecs[v].expFe);
      checkOutput("row_overrun", ovSeen - ov0, vecs[v].expOv);
      checkOutput("row_fifo_count", {29'd0, fifo_count}, vecs[v].expCount);
      if (vecs[v].expAccept && prevExpCount == 0) checkLatency("row_latency");
      if (vecs[v].ready) checkOutput("row_drained", sb.size(), 0);
      prevExpCount = vecs[v].expCount;
    end

    // A 40-clock low pulse is shorter than half a bit and must be discarded silently.
    start_rx   = 1'b1;
    data_ready = 1'b1;
    fe0 = feSeen;
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("glitch_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("glitch_data_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("glitch_frame_err", feSeen - fe0, 32'd0);

    // Queue one byte, then reset in the middle of the next frame.
    data_ready = 1'b0;
    sb.push_back(8'h99);
    applyStimulus(8'h99, 1'b1, -1);
    checkOutput("prereset_count", {29'd0, fifo_count}, 32'd1);
    checkOutput("prereset_head", {24'd0, data_out}, 32'h99);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h77 >> i) & 8'h01;
      repeat (BIT_CLK) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("midreset_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("midreset_data_out",   {24'd0, data_out},   32'd0);
    checkOutput("midreset_frame_err",  {31'd0, frame_err},  32'd0);
    checkOutput("midreset_overrun",    {31'd0, overrun},    32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (2000) @(negedge clk);

    data_ready = 1'b1;
    riseCycle = -1;
    sb.push_back(8'h88);
    applyStimulus(8'h88, 1'b1, -1);
    checkLatency("postreset_latency");
    checkOutput("postreset_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("postreset_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end
endmodule
